dmem_arbiter: RTL

Two-requester arbiter and sequencer in front of the single-port word-addressed data memory. Shares the memory between the core load/store unit (port 0) and a DMA/debug master (port 1) with round-robin priority. Absorbs the memory's one-cycle registered read latency. Implements byte-enabled stores as read-modify-write, because the memory only supports full-word writes.

---
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request/command in, grant and
// load-return out. The requester owns the master side, the arbiter the slave side.
interface dmem_arbiter_if #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [BE_W-1:0] be;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of a single-port, full-word-write data memory.
// Hides the one-cycle read latency and turns byte-enabled stores into read-modify-write.
module dmem_arbiter #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   p0,
  dmem_arbiter_if.slave   p1,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW_MERGE
  } state_t;

  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state;
  state_t          state_next;
  logic            last;
  logic            owner;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [BE_W-1:0] be_q;

  logic            win;
  logic            grant;
  logic            rvalid0;
  logic            rvalid1;
  logic            win_we;
  logic [XLEN-1:0] win_addr;
  logic [XLEN-1:0] win_wdata;
  logic [BE_W-1:0] win_be;
  logic [XLEN-1:0] merged;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    if (p0.req && p1.req) win = ~last;
    else                  win = p1.req;
    win_we    = win ? p1.we    : p0.we;
    win_addr  = win ? p1.addr  : p0.addr;
    win_wdata = win ? p1.wdata : p0.wdata;
    win_be    = win ? p1.be    : p0.be;
  end

  always_comb begin
    merged = '0;
    for (int k = 0; k < BE_W; k++) begin
      merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : mem_rdata[8*k +: 8];
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_next  = state;
    grant       = 1'b0;
    rvalid0     = 1'b0;
    rvalid1     = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    // NOTE: reset is synchronous, so the reset cycle itself must be silenced here;
    // otherwise a held request would be granted or a merge written before the edge.
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (p0.req || p1.req) begin
            grant = 1'b1;
            if (!win_we) begin
              mem_re      = 1'b1;
              mem_address = win_addr & WORD_MASK;
              state_next  = RD_WAIT;
            end else if (&win_be) begin
              mem_we      = 1'b1;
              mem_wdata   = win_wdata;
              mem_address = win_addr & WORD_MASK;
            end else if (|win_be) begin
              mem_re      = 1'b1;
              mem_address = win_addr & WORD_MASK;
              state_next  = RMW_MERGE;
            end
          end
        end
        RD_WAIT: begin
          mem_address = addr_q & WORD_MASK;
          rvalid0     = ~owner;
          rvalid1     = owner;
          state_next  = IDLE;
        end
        RMW_MERGE: begin
          mem_address = addr_q & WORD_MASK;
          mem_we      = 1'b1;
          mem_wdata   = merged;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      if (grant) last <= win;
    end
  end

  // NOTE: the payload registers carry no reset; they are only read in states that
  // are entered through a grant, which always loads them first.
  always_ff @(posedge clk) begin
    if (grant) begin
      owner   <= win;
      addr_q  <= win_addr;
      wdata_q <= win_wdata;
      be_q    <= win_be;
    end
  end

  assign busy     = !reset && (state != IDLE);
  assign p0.gnt   = grant & ~win;
  assign p1.gnt   = grant & win;
  assign p0.rvalid = rvalid0;
  assign p1.rvalid = rvalid1;
  assign p0.rdata  = rvalid0 ? mem_rdata : '0;
  assign p1.rdata  = rvalid1 ? mem_rdata : '0;

endmodule
